// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer and related load/store queues.
package sb_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-3:0] wadr;
    logic [SB_DW-1:0] data;
    logic             valid;
  } sb_entry_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over a circular queue; returns the hit offset relative to head.
// Purely combinational, no backpressure.
module sb_fwd_match #(
  parameter int N  = 4,
  parameter int KW = 30,
  parameter int PW = 2
) (
  input  logic [N-1:0][KW-1:0] keys_i,
  input  logic [N-1:0]         vld_i,
  input  logic [PW-1:0]        head_i,
  input  logic [KW-1:0]        key_i,
  output logic                 hit_o,
  output logic [PW-1:0]        rel_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_o = 1'b0;
    rel_o = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = head_i + PW'(i);
      if (vld_i[idx] && (keys_i[idx] == key_i)) begin
        hit_o = 1'b1;
        rel_o = PW'(i);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: stores retire in one cycle, drain in order on valid/ready, 1-cycle store-to-bus.
// Loads forward from the youngest pending store; a store to a full buffer with no dequeue is dropped.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemWrite,
  input  logic [AW-1:0]        DataAdr,
  input  logic [DW-1:0]        WriteData,
  output logic                 fwd_hit,
  output logic [DW-1:0]        fwd_data,
  output logic                 bus_valid,
  input  logic                 bus_ready,
  output logic [AW-1:0]        bus_adr,
  output logic [DW-1:0]        bus_wdata,
  output logic                 full,
  output logic                 empty,
  output logic [clog2(DEPTH):0] count,
  output logic                 overflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail_m1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          deq, enq, merge, drop;
  logic [AW-3:0] wadr_in;
  logic          unused_lsb;

  assign wadr_in    = DataAdr[AW-1:2];
  assign unused_lsb = ^DataAdr[1:0];
  assign tail_m1    = tail_q - PW'(1);

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign overflow = ovf_q;

  // Merging is limited to count>=2 so the head presented to the bus never changes under it.
  always_comb begin
    deq   = ~empty & bus_ready;
    merge = MemWrite && (cnt_q >= CW'(2)) && (ent_q[tail_m1].wadr == wadr_in);
    enq   = MemWrite && !merge && (!full || deq);
    drop  = MemWrite && !merge && full && !deq;
    head_d = head_q + PW'(deq);
    tail_d = tail_q + PW'(enq);
    cnt_d  = cnt_q + CW'(enq) - CW'(deq);
    ovf_d  = ovf_q | drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      if (deq) ent_q[head_q].valid <= 1'b0;
      if (enq) ent_q[tail_q] <= '{wadr: wadr_in, data: WriteData, valid: 1'b1};
      if (merge) ent_q[tail_m1].data <= WriteData;
    end
  end

  assign bus_valid = ~empty;
  assign bus_adr   = bus_valid ? {ent_q[head_q].wadr, 2'b00} : '0;
  assign bus_wdata = bus_valid ? ent_q[head_q].data : '0;

  logic [DEPTH-1:0][AW-3:0] keys;
  logic [DEPTH-1:0]         vlds;
  logic                     m_hit;
  logic [PW-1:0]            m_rel, m_idx;

  always_comb begin
    keys = '0;
    vlds = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keys[i] = ent_q[i].wadr;
      vlds[i] = ent_q[i].valid;
    end
  end

  sb_fwd_match #(.N(DEPTH), .KW(AW-2), .PW(PW)) u_fwd (
    .keys_i (keys),
    .vld_i  (vlds),
    .head_i (head_q),
    .key_i  (wadr_in),
    .hit_o  (m_hit),
    .rel_o  (m_rel)
  );

  assign m_idx    = head_q + m_rel;
  assign fwd_hit  = m_hit;
  assign fwd_data = m_hit ? ent_q[m_idx].data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; a negedge monitor checks drained writes against an expected queue.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          bus_valid;
  logic          bus_ready;
  logic [AW-1:0] bus_adr;
  logic [DW-1:0] bus_wdata;
  logic          full, empty;
  logic [2:0]    count;
  logic          overflow;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_adr   (bus_adr),
    .bus_wdata (bus_wdata),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.adr = a;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    cyc();
    MemWrite  = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (empty) break;
      cyc();
    end
    check(name, {31'd0, empty}, 32'd1);
  endtask

  // Scoreboard monitor: a handshake seen here completes at the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus_valid && bus_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL drain_unexpected: got adr %h data %h expected no transfer", bus_adr, bus_wdata);
        end else begin
          e = exp_q.pop_front();
          if (bus_adr !== e.adr || bus_wdata !== e.dat) begin
            n_fail++;
            $display("FAIL drain: got adr %h data %h expected adr %h data %h",
                     bus_adr, bus_wdata, e.adr, e.dat);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; bus_ready = 1'b0;
    #2;
    check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_bus_adr", bus_adr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    check("rst_fwd_data", fwd_data, 32'd0);
    cyc(); cyc();
    reset = 1'b1;

    // 1: single store, one-cycle latency to bus
    bus_ready = 1'b1;
    push(32'h64, 32'd7);
    st(32'h64, 32'd7);
    check("t1_bus_valid", {31'd0, bus_valid}, 32'd1);
    check("t1_bus_adr", bus_adr, 32'h64);
    check("t1_bus_wdata", bus_wdata, 32'd7);
    cyc();
    check("t1_empty", {31'd0, empty}, 32'd1);

    // 2: fill, overflow, in-order drain
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h60 + 32'(4*i), 32'hA0 + 32'(i));
      st(32'h60 + 32'(4*i), 32'hA0 + 32'(i));
    end
    check("t2_full", {31'd0, full}, 32'd1);
    check("t2_count", {29'd0, count}, 32'd4);
    st(32'h70, 32'hBAD);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    check("t2_count_drop", {29'd0, count}, 32'd4);
    bus_ready = 1'b1;
    wait_empty("t2_drain_done", 20);
    check("t2_overflow_sticky", {31'd0, overflow}, 32'd1);

    // 3: merge of back-to-back stores to one word
    bus_ready = 1'b0;
    push(32'h60, 32'd1);
    st(32'h60, 32'd1);
    st(32'h64, 32'd2);
    push(32'h64, 32'd3);
    st(32'h64, 32'd3);
    check("t3_count_merge", {29'd0, count}, 32'd2);
    bus_ready = 1'b1;
    wait_empty("t3_drain_done", 20);

    // 4: forwarding picks the youngest match
    bus_ready = 1'b0;
    push(32'h60, 32'd5); st(32'h60, 32'd5);
    push(32'h64, 32'd6); st(32'h64, 32'd6);
    push(32'h60, 32'd9); st(32'h60, 32'd9);
    DataAdr = 32'h60; #1;
    check("t4_hit_60", {31'd0, fwd_hit}, 32'd1);
    check("t4_data_60", fwd_data, 32'd9);
    DataAdr = 32'h64; #1;
    check("t4_data_64", fwd_data, 32'd6);
    DataAdr = 32'h80; #1;
    check("t4_hit_80", {31'd0, fwd_hit}, 32'd0);
    check("t4_data_80", fwd_data, 32'd0);
    MemWrite = 1'b1; WriteData = 32'h55; #1;
    check("t4_capture_invisible", {31'd0, fwd_hit}, 32'd0);
    push(32'h80, 32'h55);
    cyc();
    MemWrite = 1'b0;
    check("t4_hit_after_capture", {31'd0, fwd_hit}, 32'd1);
    check("t4_data_after_capture", fwd_data, 32'h55);
    bus_ready = 1'b1;
    wait_empty("t4_drain_done", 20);

    // 5: store accepted when full with same-cycle dequeue; pointers wrap
    reset = 1'b0; #1; reset = 1'b1;
    check("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
    bus_ready = 1'b0;
    push(32'h10, 32'h10); st(32'h11, 32'h10);
    push(32'h14, 32'h14); st(32'h16, 32'h14);
    push(32'h18, 32'h18); st(32'h1B, 32'h18);
    push(32'h1C, 32'h1C); st(32'h1C, 32'h1C);
    check("t5_full", {31'd0, full}, 32'd1);
    bus_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push(32'h90 + 32'(4*k), 32'h90 + 32'(k));
      st(32'h90 + 32'(4*k), 32'h90 + 32'(k));
      check("t5_count_steady", {29'd0, count}, 32'd4);
    end
    check("t5_no_overflow", {31'd0, overflow}, 32'd0);
    wait_empty("t5_drain_done", 20);

    // 6: asynchronous reset while entries are pending
    bus_ready = 1'b0;
    st(32'h20, 32'h20);
    st(32'h24, 32'h24);
    st(32'h28, 32'h28);
    bus_ready = 1'b1;
    push(32'h20, 32'h20);
    cyc();
    bus_ready = 1'b0;
    check("t6_valid_before", {31'd0, bus_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_bus_valid_async", {31'd0, bus_valid}, 32'd0);
    check("t6_count_async", {29'd0, count}, 32'd0);
    check("t6_empty_async", {31'd0, empty}, 32'd1);
    cyc();
    reset = 1'b1;
    cyc();
    check("scoreboard_leftover", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
